muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: opcode encodings,
// FSM state type and small arithmetic helpers.
package muldiv_unit_pkg;

    localparam int XLEN_P = 32;

    // RV32M funct7 value shared by every M-extension instruction
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Two's-complement negate when neg is set, pass-through otherwise
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? ((~v) + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        return neg ? ((~v) + 64'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Fixed latency: 32 shift-add or
// restoring-divide steps on operand magnitudes, one sign/special-case fix-up
// cycle, then a one-cycle done pulse. Result is held until the next op ends.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [5:0]          cnt_r;
    logic [2:0]          op_r;
    logic                sign_a_r;
    logic                sign_b_r;
    logic [XLEN-1:0]     amag_r;
    logic [XLEN-1:0]     bmag_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     result_r;
    logic                ready_r;
    logic                done_r;

    logic                accept_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic [XLEN-1:0]     amag_s;
    logic [XLEN-1:0]     bmag_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN+1:0]     div_try_s;
    logic [2*XLEN-1:0]   step_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     a_orig_s;
    logic                div_zero_s;
    logic                div_ovf_s;
    logic [XLEN-1:0]     fix_result_s;
    logic                ready_nxt_s;
    logic                done_nxt_s;

    // flush has priority over a simultaneous start in IDLE
    assign accept_s = (state_r == ST_IDLE) && start && !flush;

    // Operand sign flags and magnitudes derived at accept time
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                sign_a_s = srca[XLEN-1];
                sign_b_s = srcb[XLEN-1];
            end
            F3_MULHSU: begin
                sign_a_s = srca[XLEN-1];
                sign_b_s = 1'b0;
            end
            default: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
        endcase
        amag_s = cond_neg32(srca, sign_a_s);
        bmag_s = cond_neg32(srcb, sign_b_s);
    end

    // One iteration step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, bmag_r} : {(XLEN+1){1'b0}});
        div_try_s = {1'b0, acc_r[2*XLEN-1:XLEN-1]} - {2'b00, bmag_r};
        if (op_r[2]) begin
            if (!div_try_s[XLEN+1]) begin
                step_s = {div_try_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                step_s = {acc_r[2*XLEN-2:0], 1'b0};
            end
        end else begin
            step_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign correction and special-case selection evaluated during FIX
    always_comb begin
        prod_s     = cond_neg64(acc_r, sign_a_r ^ sign_b_r);
        quot_s     = cond_neg32(acc_r[XLEN-1:0], sign_a_r ^ sign_b_r);
        rem_s      = cond_neg32(acc_r[2*XLEN-1:XLEN], sign_a_r);
        a_orig_s   = cond_neg32(amag_r, sign_a_r);
        div_zero_s = (bmag_r == 32'd0);
        div_ovf_s  = ((op_r == F3_DIV) || (op_r == F3_REM)) && sign_a_r && sign_b_r &&
                     (amag_r == 32'h8000_0000) && (bmag_r == 32'd1);
        case (op_r)
            F3_MUL: fix_result_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU: begin
                if (div_zero_s) begin
                    fix_result_s = 32'hFFFF_FFFF;
                end else if (div_ovf_s) begin
                    fix_result_s = 32'h8000_0000;
                end else begin
                    fix_result_s = quot_s;
                end
            end
            F3_REM, F3_REMU: begin
                if (div_zero_s) begin
                    fix_result_s = a_orig_s;
                end else if (div_ovf_s) begin
                    fix_result_s = 32'd0;
                end else begin
                    fix_result_s = rem_s;
                end
            end
            default: fix_result_s = 32'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == 6'(XLEN - 1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode of the upcoming state, registered below
    always_comb begin
        ready_nxt_s = (state_nxt_s == ST_IDLE);
        done_nxt_s  = (state_nxt_s == ST_DONE);
    end

    // Registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            ready_r <= ready_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Datapath: operand capture on accept, one iteration per CALC cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= 6'd0;
            op_r     <= 3'd0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            amag_r   <= 32'd0;
            bmag_r   <= 32'd0;
            acc_r    <= 64'd0;
        end else if (accept_s) begin
            cnt_r    <= 6'd0;
            op_r     <= funct3;
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            amag_r   <= amag_s;
            bmag_r   <= bmag_s;
            acc_r    <= {32'd0, amag_s};
        end else if (state_r == ST_CALC) begin
            cnt_r    <= cnt_r + 6'd1;
            acc_r    <= step_s;
        end
    end

    // Result register, written only when FIX completes into DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r <= 32'd0;
        end else if ((state_r == ST_FIX) && (state_nxt_s == ST_DONE)) begin
            result_r <= fix_result_s;
        end
    end

    assign ready  = ready_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int tests;
    int fails;
    int done_seen;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .srca   (srca),
        .srcb   (srcb),
        .flush  (flush),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, check accept, latency (done 33 edges after accept edge),
    // result value, and the return to IDLE. poke pulses start during CALC.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit poke);
        int lat;
        @(negedge clk);
        funct3 = f3; srca = a; srcb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; srca = 32'hDEAD_BEEF; srcb = 32'h0000_0003; funct3 = 3'b000;
        check({tag, "_busy"}, {31'd0, ready}, 32'd0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (poke && k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, 32'd33);
        check({tag, "_res"}, result, exp);
        @(posedge clk); #1;
        check({tag, "_rdy"}, {30'd0, ready, done}, 32'd2);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; srca = 32'd0; srcb = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk); reset = 1'b0;

        run_op("mul",     3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh",    3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("divu",    3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
        run_op("remu",    3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op("div0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("divu0",   3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("rem0",    3'b110, 32'd5, 32'd0, 32'd5, 1'b0);
        run_op("remu0",   3'b111, 32'd5, 32'd0, 32'd5, 1'b0);
        run_op("remneg0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0);
        run_op("divovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("removf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("mul2",    3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
        run_op("mulhu2",  3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0);

        // flush and start together in IDLE: not accepted
        @(negedge clk);
        funct3 = 3'b101; srca = 32'd9; srcb = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", {31'd0, ready}, 32'd1);

        // flush during CALC at cycle +10
        @(negedge clk);
        funct3 = 3'b101; srca = 32'd100; srcb = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy", {31'd0, ready}, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", {31'd0, ready}, 32'd1);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("flush_nodone", done_seen, 32'd0);
        check("flush_result", result, 32'd1);

        // reset asserted at cycle +20 of an op
        @(negedge clk);
        funct3 = 3'b000; srca = 32'd3; srcb = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk); reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("rst_mid_nodone", done_seen, 32'd0);
        run_op("after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
